pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 155 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_controller
//  Purpose  : Stall/flush/freeze control for a 5-stage pipeline with a
//             load-use interlock, branch flush and a bounded memory wait.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RS_ID,
    input  logic [4:0]  RT_ID,
    input  logic [4:0]  RT_EX,
    input  logic        MemRead_EX,
    input  logic        BranchTaken_EX,
    input  logic        MemReq,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        Pipe_Freeze,
    output logic        MemTimeout,
    output logic [15:0] StallCycles,
    output logic [15:0] FlushCount
);

    localparam logic [0:0] c_RUN     = 1'b0;
    localparam logic [0:0] c_MEMWAIT = 1'b1;
    localparam logic [3:0] c_WAIT_MAX = 4'd15;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [3:0]  r_wait_cnt;
    logic        r_mem_timeout;
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    logic        w_load_use;
    logic        w_mem_wait;
    logic        w_mem_done;
    logic        w_timeout;
    logic        w_flush_event;

    assign w_load_use = MemRead_EX && (RT_EX != 5'd0) &&
                        ((RT_EX == RS_ID) || (RT_EX == RT_ID));
    assign w_mem_wait = MemReq && !MemReady;
    // Dropping the request mid-wait is treated as the access having finished.
    assign w_mem_done = !MemReq || MemReady;
    assign w_flush_event = (r_state == c_RUN) && !w_mem_wait && BranchTaken_EX;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            c_RUN: begin
                if (w_mem_wait) begin
                    w_state_next = c_MEMWAIT;
                end
            end
            c_MEMWAIT: begin
                if (w_mem_done) begin
                    w_state_next = c_RUN;
                end else if (r_wait_cnt == c_WAIT_MAX) begin
                    w_state_next = c_RUN;
                    w_timeout    = 1'b1;
                end
            end
            default: w_state_next = c_RUN;
        endcase
    end

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        Pipe_Freeze  = 1'b0;
        case (r_state)
            c_RUN: begin
                if (w_mem_wait) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    Pipe_Freeze = 1'b1;
                end else if (BranchTaken_EX) begin
                    IF_ID_Flush  = 1'b1;
                    ID_EX_Bubble = 1'b1;
                end else if (w_load_use) begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                end
            end
            c_MEMWAIT: begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                Pipe_Freeze = 1'b1;
            end
            default: begin
                PCWrite     = 1'b1;
                IF_ID_Write = 1'b1;
            end
        endcase
    end

    // Counter is held at zero in RUN, so every MEMWAIT entry starts from 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state == c_RUN || w_timeout) begin
            r_wait_cnt <= 4'd0;
        end else if (!MemReady) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 16'd0;
        end else if (!PCWrite && r_stall_cycles != c_CNT_MAX) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_count <= 16'd0;
        end else if (w_flush_event && r_flush_count != c_CNT_MAX) begin
            r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign MemTimeout  = r_mem_timeout;
    assign StallCycles = r_stall_cycles;
    assign FlushCount  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_controller
//  Purpose  : Directed self-checking bench for pipeline_hazard_controller.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  RS_ID, RT_ID, RT_EX;
    logic        MemRead_EX, BranchTaken_EX, MemReq, MemReady;
    logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, MemTimeout;
    logic [15:0] StallCycles, FlushCount;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_hazard_controller dut (
        .clk            (clk),
        .reset          (reset),
        .RS_ID          (RS_ID),
        .RT_ID          (RT_ID),
        .RT_EX          (RT_EX),
        .MemRead_EX     (MemRead_EX),
        .BranchTaken_EX (BranchTaken_EX),
        .MemReq         (MemReq),
        .MemReady       (MemReady),
        .PCWrite        (PCWrite),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Bubble   (ID_EX_Bubble),
        .Pipe_Freeze    (Pipe_Freeze),
        .MemTimeout     (MemTimeout),
        .StallCycles    (StallCycles),
        .FlushCount     (FlushCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RS_ID = 5'd0; RT_ID = 5'd0; RT_EX = 5'd0;
        MemRead_EX = 1'b0; BranchTaken_EX = 1'b0;
        MemReq = 1'b0; MemReady = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze}
    task automatic check_ctrl(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze},
              {27'd0, exp});
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        check("rst_stall", 32'(StallCycles), 32'd0);
        check("rst_flush", 32'(FlushCount), 32'd0);
        check("rst_tmo",   32'(MemTimeout), 32'd0);
        check_ctrl("rst_ctrl_normal", 5'b11000);

        // Load-use via rs
        MemRead_EX = 1'b1; RT_EX = 5'd5; RS_ID = 5'd5; RT_ID = 5'd9;
        #1;
        check_ctrl("lu_rs_ctrl", 5'b00010);
        check("lu_rs_stall_before", 32'(StallCycles), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("lu_rs_stall_after", 32'(StallCycles), 32'd1);
        check_ctrl("lu_rs_one_cycle", 5'b11000);

        // Load-use via rt
        MemRead_EX = 1'b1; RT_EX = 5'd7; RS_ID = 5'd3; RT_ID = 5'd7;
        #1;
        check_ctrl("lu_rt_ctrl", 5'b00010);
        tick();
        idle_inputs();
        #1;
        check("lu_rt_stall", 32'(StallCycles), 32'd2);

        // Register 0 never hazards
        MemRead_EX = 1'b1; RT_EX = 5'd0; RS_ID = 5'd0; RT_ID = 5'd0;
        #1;
        check_ctrl("r0_no_stall", 5'b11000);
        tick();
        check("r0_stall_same", 32'(StallCycles), 32'd2);

        // Matching registers but not a load
        MemRead_EX = 1'b0; RT_EX = 5'd4; RS_ID = 5'd4;
        #1;
        check_ctrl("noload_no_stall", 5'b11000);
        tick();
        idle_inputs();

        // Branch beats load-use
        MemRead_EX = 1'b1; RT_EX = 5'd5; RS_ID = 5'd5; BranchTaken_EX = 1'b1;
        #1;
        check_ctrl("br_lu_ctrl", 5'b11110);
        check("br_flush_before", 32'(FlushCount), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("br_flush_after", 32'(FlushCount), 32'd1);
        check("br_stall_same", 32'(StallCycles), 32'd2);

        // Memory wait: 3 cycles not ready, then ready
        do_reset();
        MemReq = 1'b1; MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MemReady = (i == 3);
            BranchTaken_EX = (i == 1);
            MemRead_EX = (i == 2); RT_EX = 5'd6; RS_ID = 5'd6;
            #1;
            check_ctrl($sformatf("mw_freeze_%0d", i), 5'b00001);
            tick();
        end
        idle_inputs();
        #1;
        check_ctrl("mw_back_run", 5'b11000);
        check("mw_stall", 32'(StallCycles), 32'd4);
        check("mw_tmo", 32'(MemTimeout), 32'd0);
        check("mw_no_flush", 32'(FlushCount), 32'd0);

        // Memory timeout after 16 MEMWAIT cycles
        do_reset();
        MemReq = 1'b1; MemReady = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            check($sformatf("tmo_low_%0d", c), 32'(MemTimeout), 32'd0);
            tick();
        end
        check("tmo_set", 32'(MemTimeout), 32'd1);
        MemReq = 1'b0;
        #1;
        check_ctrl("tmo_reenter_run", 5'b11000);
        MemReq = 1'b1;
        #1;
        tick();
        tick();
        tick();
        check("tmo_held", 32'(MemTimeout), 32'd1);
        MemReq = 1'b0;
        tick();
        check("tmo_stall", 32'(StallCycles), 32'd21);
        check("tmo_held_run", 32'(MemTimeout), 32'd1);
        check_ctrl("tmo_run_ctrl", 5'b11000);
        do_reset();
        check("tmo_cleared", 32'(MemTimeout), 32'd0);

        // Reset aborts a wait in progress
        MemReq = 1'b1; MemReady = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_ctrl("rst_mw_still_frozen", 5'b00001);
        tick();
        reset = 1'b0;
        MemReq = 1'b0;
        #1;
        check_ctrl("rst_mw_run", 5'b11000);
        check("rst_mw_tmo", 32'(MemTimeout), 32'd0);
        check("rst_mw_stall", 32'(StallCycles), 32'd0);

        // Saturation of StallCycles
        MemRead_EX = 1'b1; RT_EX = 5'd5; RS_ID = 5'd5;
        repeat (65534) tick();
        check("sat_preload", 32'(StallCycles), 32'h0000FFFE);
        repeat (3) tick();
        check("sat_final", 32'(StallCycles), 32'h0000FFFF);
        check_ctrl("sat_still_stalling", 5'b00010);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
